// File: rtl/adder_sum_accumulator.sv
// Accumulates 8-bit adder sums over valid/ready, tracks a saturating sample
// count and a sticky wrap flag, and streams a {acc_lo, acc_hi, count} snapshot on request.
module adder_sum_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic             clear,
  input  logic             dump,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DUMP_LO  = 2'd1,
    DUMP_HI  = 2'd2,
    DUMP_CNT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] snap_acc_q, snap_acc_d;
  logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;

  logic             accept;
  logic [ACC_W:0]   acc_sum;
  logic [15:0]      snap_ext;

  assign sum_ready = rst_n && ena && (state_q == IDLE) && !clear;
  assign accept    = sum_valid && sum_ready;
  assign acc_sum   = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, sum_in};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    snap_acc_d = snap_acc_q;
    snap_cnt_d = snap_cnt_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end else begin
            if (accept) begin
              acc_d = acc_sum[ACC_W-1:0];
              if (acc_sum[ACC_W]) ovf_d = 1'b1;
              if (count_q != '1) count_d = count_q + 1'b1;
            end
            // Snapshot takes the post-update values so a same-cycle sum is included
            if (dump) begin
              state_d    = DUMP_LO;
              snap_acc_d = acc_d;
              snap_cnt_d = count_d;
            end
          end
        end
        DUMP_LO:  state_d = DUMP_HI;
        DUMP_HI:  state_d = DUMP_CNT;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      snap_acc_q <= '0;
      snap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      snap_acc_q <= snap_acc_d;
      snap_cnt_q <= snap_cnt_d;
    end
  end

  assign snap_ext = 16'(snap_acc_q);

  always_comb begin
    byte_out = '0;
    if (byte_valid) begin
      case (state_q)
        DUMP_LO:  byte_out = snap_ext[7:0];
        DUMP_HI:  byte_out = snap_ext[15:8];
        DUMP_CNT: byte_out = snap_cnt_q;
        default:  byte_out = '0;
      endcase
    end
  end

  assign byte_valid = (state_q != IDLE) && ena;
  assign busy       = (state_q != IDLE);
  assign acc_out    = acc_q;
  assign count_out  = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Randomized and directed bench for adder_sum_accumulator, checked every cycle
// against a queue-based model of the accumulate / snapshot-stream behaviour.
module tb_adder_sum_accumulator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic [7:0]   sum_in = '0;
  logic         sum_valid = 1'b0;
  logic         sum_ready;
  logic         clear = 1'b0;
  logic         dump = 1'b0;
  logic [W-1:0] acc_out;
  logic [7:0]   count_out;
  logic         overflow;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  adder_sum_accumulator #(.ACC_W(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sum_in(sum_in),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .clear(clear), .dump(dump),
    .acc_out(acc_out), .count_out(count_out), .overflow(overflow),
    .byte_out(byte_out), .byte_valid(byte_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: running total as plain integers, pending snapshot bytes as a queue
  int unsigned m_acc = 0;
  int unsigned m_cnt = 0;
  bit          m_ovf = 0;
  byte unsigned m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_ovf = 0; m_q.delete();
    end else if (ena) begin
      if (m_q.size() > 0) begin
        void'(m_q.pop_front());
      end else if (clear) begin
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else begin
        if (sum_valid) begin
          m_acc = m_acc + sum_in;
          if (m_acc >= (1 << W)) begin
            m_ovf = 1;
            m_acc = m_acc - (1 << W);
          end
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
        if (dump) begin
          m_q.push_back(byte'(m_acc % 256));
          m_q.push_back(byte'(m_acc / 256));
          m_q.push_back(byte'(m_cnt));
        end
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Single per-cycle compare against the model, 1ns after inputs change
  always @(negedge clk) begin
    #1;
    chk("acc_out", acc_out, m_acc);
    chk("count_out", count_out, m_cnt);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, (m_q.size() > 0) && rst_n);
    chk("byte_valid", byte_valid, (m_q.size() > 0) && ena && rst_n);
    chk("sum_ready", sum_ready, rst_n && ena && (m_q.size() == 0) && !clear);
    if (m_q.size() > 0 && ena && rst_n) chk("byte_out", byte_out, m_q[0]);
    if (!rst_n) chk("byte_out_rst", byte_out, 0);
  end

  task automatic cyc(input bit v, input logic [7:0] s, input bit clr, input bit dmp, input bit en);
    @(negedge clk);
    sum_valid = v; sum_in = s; clear = clr; dump = dmp; ena = en;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_acc", acc_out, 0);
    chk("rst_ready", sum_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bv", byte_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Accumulate
    cyc(1, 8'h1E, 0, 0, 1);
    cyc(1, 8'h1E, 0, 0, 1);
    cyc(1, 8'h05, 0, 0, 1);
    idle(1);
    chk("accum_acc", acc_out, 16'h0041);
    chk("accum_cnt", count_out, 3);
    chk("accum_ovf", overflow, 0);

    // Wrap and saturate
    cyc(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 2185; i++) cyc(1, 8'h1E, 0, 0, 1);
    idle(1);
    chk("wrap_acc", acc_out, 16'h000E);
    chk("wrap_ovf", overflow, 1);
    chk("wrap_cnt", count_out, 255);
    cyc(1, 8'h01, 0, 0, 1);
    idle(1);
    chk("sat_acc", acc_out, 16'h000F);
    chk("sat_cnt", count_out, 255);

    // Dump of 0x0123/5 with a same-cycle sum of 2
    cyc(0, 8'h00, 1, 0, 1);
    cyc(1, 8'hFF, 0, 0, 1);
    cyc(1, 8'h1E, 0, 0, 1);
    cyc(1, 8'h03, 0, 0, 1);
    cyc(1, 8'h02, 0, 0, 1);
    cyc(1, 8'h01, 0, 0, 1);
    cyc(1, 8'h02, 0, 1, 1);
    idle(1);
    chk("dump_b0", byte_out, 8'h25); chk("dump_bv0", byte_valid, 1);
    chk("dump_busy0", busy, 1);      chk("dump_rdy0", sum_ready, 0);
    idle(1);
    chk("dump_b1", byte_out, 8'h01); chk("dump_busy1", busy, 1);
    idle(1);
    chk("dump_b2", byte_out, 8'h06); chk("dump_busy2", busy, 1);
    idle(1);
    chk("dump_end_busy", busy, 0);   chk("dump_end_rdy", sum_ready, 1);

    // Priority: clear beats dump and sum
    cyc(1, 8'h10, 1, 1, 1);
    chk("prio_rdy", sum_ready, 0);
    idle(1);
    chk("prio_acc", acc_out, 0); chk("prio_cnt", count_out, 0);
    chk("prio_ovf", overflow, 0); chk("prio_busy", busy, 0);

    // Enable stall after the first byte
    cyc(1, 8'hAB, 0, 0, 1);
    cyc(1, 8'hCD, 0, 1, 1);
    idle(1);
    chk("stall_b0", byte_out, 8'h78);
    cyc(0, 8'h00, 0, 0, 0);
    chk("stall_bv_a", byte_valid, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("stall_bv_b", byte_valid, 0);
    idle(1);
    chk("stall_b1", byte_out, 8'h01);
    idle(1);
    chk("stall_b2", byte_out, 8'h02);
    idle(1);
    chk("stall_done", byte_valid, 0);

    // Asynchronous reset during DUMP_HI
    cyc(0, 8'h00, 0, 1, 1);
    idle(2);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_acc", acc_out, 0); chk("mid_cnt", count_out, 0);
    chk("mid_bv", byte_valid, 0); chk("mid_busy0", busy, 0);
    chk("mid_rdy", sum_ready, 0); chk("mid_byte", byte_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("post_rdy", sum_ready, 1);
    idle(3);
    chk("post_bv", byte_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30)),
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) != 0);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

Downstream consumer of the 4-bit adder stage: captures each 8-bit sum over a valid/ready handshake, keeps a running 16-bit total and a sample count, and on request streams a snapshot out as three bytes over an 8-bit bus. It sits between the adder's `uo_out`-style sum output and the chip-level output pins, giving the tile a stateful result path.

## Interface
- `ACC_W`, default 16: accumulator width; legal range 9..16.
- `CNT_W`, default 8: sample-counter width; fixed at 8 for the byte stream.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: tile enable; when low, all state is held.
- `sum_in` in 8: sum from the adder (0..30 in normal use; the full 8-bit range is legal).
- `sum_valid` in 1: `sum_in` is valid this cycle.
- `sum_ready` out 1: the block accepts `sum_in` this cycle.
- `clear` in 1: synchronous clear of the accumulator, count and overflow.
- `dump` in 1: request to stream a snapshot.
- `acc_out` out ACC_W: live accumulator.
- `count_out` out 8: live sample count.
- `overflow` out 1: sticky flag; accumulator has wrapped.
- `byte_out` out 8: streamed snapshot byte.
- `byte_valid` out 1: `byte_out` is valid this cycle.
- `busy` out 1: a dump is in progress.

## Operation
- The FSM has four states: IDLE, DUMP_LO, DUMP_HI, DUMP_CNT.
- `sum_ready` = `rst_n && ena && state==IDLE && !clear`. This is combinational.
- Accept condition: `sum_valid && sum_ready`.
  - `acc` ← `acc + zext(sum_in)`, modulo 2^ACC_W.
  - If the carry-out is set, `overflow` ← 1.
  - `count` ← `count + 1`, saturating at 255.
- `clear` applies only when `ena` is high.
  - In IDLE: `acc`, `count` and `overflow` go to 0. `clear` has priority over `dump` in the same cycle; the dump request is dropped.
  - In DUMP_*: `clear` is ignored.
- `dump` in IDLE (no `clear`, `ena` high):
  - Next state is DUMP_LO.
  - The snapshot registers take the post-update `acc`/`count`, so a sum accepted in the same cycle is included.
- Transitions:
  - DUMP_LO → DUMP_HI → DUMP_CNT → IDLE, one per enabled cycle.
  - `dump` is ignored while in any DUMP_* state.
- Byte stream:
  - DUMP_LO emits `snap_acc[7:0]`.
  - DUMP_HI emits `zext(snap_acc[ACC_W-1:8])`.
  - DUMP_CNT emits `snap_count`.
- `byte_valid` = `state!=IDLE && ena`.
- `busy` = `state!=IDLE`.
- `ena` low: the FSM, `acc`, `count`, `overflow` and the snapshot are frozen. `byte_valid` = 0. The stream resumes on the same byte when `ena` returns high.

## Timing
- Reset values: `acc_out`=0, `count_out`=0, `overflow`=0, `byte_out`=0, `byte_valid`=0, `busy`=0, `sum_ready`=0 while `rst_n` is low. The state is IDLE.
- Accept latency: `acc_out`/`count_out` reflect an accepted sum one cycle after the accepting edge.
- Dump latency:
  - `dump` sampled at edge N → first byte valid in cycle N+1.
  - Bytes occupy cycles N+1, N+2, N+3.
  - `sum_ready` is low in cycles N+1..N+3 and high again in cycle N+4 (if `ena` is high).
- Back-to-back dumps: a `dump` held high in cycle N+4 starts a new stream at N+5. A sum presented in N+4 is accepted and included in that snapshot.
- Reset mid-dump: the stream aborts immediately (asynchronous). No further bytes are emitted; the state is IDLE.
- `sum_valid` while `sum_ready` is low: the sum is not consumed; the producer must hold it.

## Test plan
- **Accumulate:** after reset, present sums 0x1E, 0x1E, 0x05 with `ena`=1 → `acc_out`=0x0041, `count_out`=3, `overflow`=0.
- **Wrap and saturate:** 2185 accepted sums of 0x1E → `acc_out`=0x000E, `overflow`=1, `count_out`=255. One more sum of 0x01 → `acc_out`=0x000F, `count_out` stays 255.
- **Dump:** with `acc`=0x0123 and `count`=5, pulse `dump` together with `sum_valid`/`sum_in`=0x02 → bytes 0x25, 0x01, 0x06 on three consecutive cycles. `busy` is high for 3 cycles; `sum_ready` is low during the stream.
- **Priority:** in one IDLE cycle, assert `clear`, `dump` and `sum_valid` (`sum_in`=0x10) together → `sum_ready`=0, `acc_out`=0, `count_out`=0, `overflow`=0, no stream.
- **Enable stall:** drop `ena` for 2 cycles after the first dump byte → `byte_valid`=0 during the stall. The remaining bytes resume unchanged; the total stream is still exactly 3 bytes.
- **Reset mid-dump:** assert `rst_n`=0 during DUMP_HI → all outputs are 0 immediately. After release, `sum_ready`=1 with `ena` high and no residual bytes appear.
